task5: RTL and testbench

- Single-round baccarat engine for the DE1-SoC top level.
- A free-running card counter cycles values 1..13 on every clock; a step key deals the current counter value to the next hand slot.
- The game state machine applies baccarat drawing rules and shows cards on six 7-segment displays.
- Scores and win lights appear on LEDR.

---
 rtl/task5.sv | 156 +++++++++++++++
 tb/tb_task5.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/task5.sv
// Single-round baccarat engine: free-running 1..13 card counter, rising-edge
// step on KEY[0] deals the current counter value into the next hand slot,
// drawing rules decide the third cards, six 7-segment card displays, scores
// and win lights on LEDR.
// Optional macro GAME_RESTART_EN: a step in DONE clears the table and starts
// a new round (counter unaffected). Undefined: DONE holds until reset.

// Card rank to active-low 7-segment pattern (gfedcba); 0 and 14..15 blank.
module task5_seg (
   input  logic [3:0] card_i,
   output logic [6:0] seg_o
);
   // Plain lookup of the rank glyph
   always_comb begin
      seg_o = 7'b1111111;
      case (card_i)
         4'd1:  seg_o = 7'b0001000;
         4'd2:  seg_o = 7'b0100100;
         4'd3:  seg_o = 7'b0110000;
         4'd4:  seg_o = 7'b0011001;
         4'd5:  seg_o = 7'b0010010;
         4'd6:  seg_o = 7'b0000010;
         4'd7:  seg_o = 7'b1111000;
         4'd8:  seg_o = 7'b0000000;
         4'd9:  seg_o = 7'b0010000;
         4'd10: seg_o = 7'b1000000;
         4'd11: seg_o = 7'b1100001;
         4'd12: seg_o = 7'b0011000;
         4'd13: seg_o = 7'b0001001;
         default: seg_o = 7'b1111111;
      endcase
   end
endmodule

module task5 (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] KEY,
   output logic [9:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);
   // Slots 0..2 are player cards 1..3, slots 3..5 dealer cards 1..3.
   localparam int NUM_SLOTS = 6;

   typedef enum logic [2:0] {PC1, DC1, PC2, DC2, PC3, DC3, DONE} state_t;

   state_t                     state_q, state_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic                       hist_q;
   logic                       step;
   logic [NUM_SLOTS-1:0][3:0]  card_q, card_d;
   logic [NUM_SLOTS-1:0][6:0]  seg;
   logic [3:0]                 pscore, dscore, dscore_dc2, tval;
   logic                       done, pwin, dwin;

   // Baccarat point value: 1..9 face value, 10/J/Q/K and empty count 0
   function automatic logic [3:0] cval(input logic [3:0] c);
      return (c <= 4'd9) ? c : 4'd0;
   endfunction

   // Hand total mod 10
   function automatic logic [3:0] score3(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c);
      logic [4:0] s, m;
      s = 5'(cval(a)) + 5'(cval(b)) + 5'(cval(c));
      m = s % 5'd10;
      return m[3:0];
   endfunction

   assign step       = KEY[0] & ~hist_q;
   assign cnt_d      = (cnt_q == 4'd13) ? 4'd1 : cnt_q + 4'd1;
   assign pscore     = score3(card_q[0], card_q[1], card_q[2]);
   assign dscore     = score3(card_q[3], card_q[4], card_q[5]);
   // Dealer total including the second dealer card being loaded this edge
   assign dscore_dc2 = score3(card_q[3], cnt_q, 4'd0);
   assign tval       = cval(cnt_q);

   // Registers: counter, key history, cards and game state
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         cnt_q   <= 4'd1;
         hist_q  <= 1'b0;
         card_q  <= '0;
         state_q <= PC1;
      end else begin
         cnt_q   <= cnt_d;
         hist_q  <= KEY[0];
         card_q  <= card_d;
         state_q <= state_d;
      end
   end

   // Next state and card loads; each step deals exactly one card
   always_comb begin
      state_d = state_q;
      card_d  = card_q;
      if (step) begin
         case (state_q)
            PC1: begin card_d[0] = cnt_q; state_d = DC1; end
            DC1: begin card_d[3] = cnt_q; state_d = PC2; end
            PC2: begin card_d[1] = cnt_q; state_d = DC2; end
            DC2: begin
               card_d[4] = cnt_q;
               // Player hand is already complete here; dealer includes new card
               if (pscore >= 4'd8 || dscore_dc2 >= 4'd8) state_d = DONE;
               else if (pscore <= 4'd5)                  state_d = PC3;
               else if (dscore_dc2 <= 4'd5)              state_d = DC3;
               else                                      state_d = DONE;
            end
            PC3: begin
               card_d[2] = cnt_q;
               // Dealer draws on the player's third-card value
               if ((dscore <= 4'd2) ||
                   (dscore == 4'd3 && tval != 4'd8) ||
                   (dscore == 4'd4 && tval >= 4'd2 && tval <= 4'd7) ||
                   (dscore == 4'd5 && tval >= 4'd4 && tval <= 4'd7) ||
                   (dscore == 4'd6 && tval >= 4'd6 && tval <= 4'd7))
                  state_d = DC3;
               else
                  state_d = DONE;
            end
            DC3: begin card_d[5] = cnt_q; state_d = DONE; end
            DONE: begin
`ifdef GAME_RESTART_EN
               card_d  = '0;
               state_d = PC1;
`else
               state_d = DONE;
`endif
            end
            default: state_d = PC1;
         endcase
      end
   end

   assign done = (state_q == DONE);
   assign pwin = done && (pscore >= dscore);
   assign dwin = done && (dscore >= pscore);
   assign LEDR = {dwin, pwin, dscore, pscore};

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_seg
      task5_seg u_seg (.card_i(card_q[i]), .seg_o(seg[i]));
   end

   assign HEX0 = seg[0];
   assign HEX1 = seg[1];
   assign HEX2 = seg[2];
   assign HEX3 = seg[3];
   assign HEX4 = seg[4];
   assign HEX5 = seg[5];
endmodule

// File: tb/tb_task5.sv
module tb_task5;
   logic       CLOCK_50;
   logic       reset;
   logic [3:0] KEY;
   logic [9:0] LEDR;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   task5 dut (.CLOCK_50(CLOCK_50), .reset(reset), .KEY(KEY), .LEDR(LEDR),
              .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
              .HEX4(HEX4), .HEX5(HEX5));

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   int total = 0;
   int bad   = 0;
   int n     = 0;   // rising edges since reset release

   // Reference model: two hands, who draws next, round over
   int pc[3], dc[3];
   int np, nd;
   int nxt;          // 0 player third card, 1 dealer third card
   bit m_done;

   function automatic int cv(input int c);
      return (c >= 1 && c <= 9) ? c : 0;
   endfunction
   function automatic int psc();
      return (cv(pc[0]) + cv(pc[1]) + cv(pc[2])) % 10;
   endfunction
   function automatic int dsc();
      return (cv(dc[0]) + cv(dc[1]) + cv(dc[2])) % 10;
   endfunction

   function automatic logic [6:0] glyph(input int c);
      case (c)
         1: return 7'b0001000;   2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;
         7: return 7'b1111000;   8: return 7'b0000000;   9: return 7'b0010000;
         10: return 7'b1000000;  11: return 7'b1100001;  12: return 7'b0011000;
         13: return 7'b0001001;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 3; i++) begin pc[i] = 0; dc[i] = 0; end
      np = 0; nd = 0; nxt = 0; m_done = 0;
   endtask

   task automatic m_deal(input int c);
      int p, d, t, tot;
      if (m_done) begin
`ifdef GAME_RESTART_EN
         m_clear();
`endif
         return;
      end
      tot = np + nd;
      if (tot < 4) begin
         if (tot % 2 == 0) begin pc[np] = c; np++; end
         else              begin dc[nd] = c; nd++; end
         if (tot == 3) begin
            p = psc(); d = dsc();
            if (p >= 8 || d >= 8) m_done = 1;
            else if (p <= 5)      nxt = 0;
            else if (d <= 5)      nxt = 1;
            else                  m_done = 1;
         end
      end else if (nxt == 0 && np == 2) begin
         pc[2] = c; np = 3;
         t = cv(c); d = dsc();
         if (d <= 2 || (d == 3 && t != 8) || (d == 4 && t >= 2 && t <= 7) ||
             (d == 5 && t >= 4 && t <= 7) || (d == 6 && t >= 6 && t <= 7))
            nxt = 1;
         else
            m_done = 1;
      end else begin
         dc[2] = c; nd = 3; m_done = 1;
      end
   endtask

   task automatic cmp(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check(input string tag);
      logic [6:0] hx[6];
      logic [9:0] led;
      int p, d;
      hx[0] = HEX0; hx[1] = HEX1; hx[2] = HEX2;
      hx[3] = HEX3; hx[4] = HEX4; hx[5] = HEX5;
      for (int i = 0; i < 6; i++)
         cmp($sformatf("%s_hex%0d", tag, i), {3'b000, hx[i]},
             {3'b000, glyph(i < 3 ? pc[i] : dc[i-3])});
      p = psc(); d = dsc();
      led = {(m_done && d >= p) ? 1'b1 : 1'b0, (m_done && p >= d) ? 1'b1 : 1'b0,
             4'(d), 4'(p)};
      cmp({tag, "_ledr"}, LEDR, led);
   endtask

   task automatic clk1();
      @(posedge CLOCK_50);
      n++;
      @(negedge CLOCK_50);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) clk1();
   endtask

   // Press then release; the card is the counter value at the press edge
   task automatic step();
      KEY[0] = 1'b1;
      m_deal((n % 13) + 1);
      clk1();
      KEY[0] = 1'b0;
      clk1();
   endtask

   task automatic deal_value(input int c);
      idle(((c - 1) - (n % 13) + 13) % 13);
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      KEY   = 4'b0000;
      m_clear();
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      n = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      KEY   = 4'b0000;
      m_clear();

      // Reset state
      @(negedge CLOCK_50);
      check("reset");
      cmp("reset_ledr0", LEDR, 10'd0);
      do_reset();
      check("after_release");

      // One immediate step deals an Ace
      step();
      check("first_step");
      cmp("first_hex0", {3'b000, HEX0}, {3'b000, 7'b0001000});

      // Case A: player natural 9
      do_reset();
      deal_value(1); deal_value(1); deal_value(8); deal_value(11);
      check("caseA");
      cmp("caseA_led", LEDR, 10'b01_0001_1001);

      // Case B: dealer natural 9
      do_reset();
      deal_value(1); deal_value(1); deal_value(1); deal_value(8);
      check("caseB");
      cmp("caseB_led", LEDR, 10'b10_1001_0010);

      // Six Aces: both draw, tie
      do_reset();
      for (int i = 0; i < 6; i++) begin
         deal_value(1);
         check($sformatf("aces%0d", i));
      end
      cmp("aces_led", LEDR, 10'b11_0011_0011);
      cmp("aces_hex2", {3'b000, HEX2}, {3'b000, 7'b0001000});
      cmp("aces_hex5", {3'b000, HEX5}, {3'b000, 7'b0001000});

      // Counter wrap: 14 idle clocks then deal a 2
      do_reset();
      idle(14);
      step();
      check("wrap");
      cmp("wrap_hex0", {3'b000, HEX0}, {3'b000, 7'b0100100});

      // Reset mid-round in DC2
      do_reset();
      step(); step(); step();
      check("pre_abort");
      reset = 1'b1;
      m_clear();
      #1;
      check("abort");
      cmp("abort_ledr", LEDR, 10'd0);
      @(negedge CLOCK_50);
      reset = 1'b0;
      n = 0;
      step();
      check("after_abort");
      cmp("after_abort_hex0", {3'b000, HEX0}, {3'b000, 7'b0001000});

      // Randomized rounds, including steps after the round is over
      for (int g = 0; g < 30; g++) begin
         int k;
         do_reset();
         idle($urandom_range(0, 30));
         k = 0;
         while (!m_done && k < 8) begin
            idle($urandom_range(0, 15));
            step();
            check($sformatf("rnd%0d_s%0d", g, k));
            k++;
         end
         for (int j = 0; j < 2; j++) begin
            idle($urandom_range(0, 5));
            step();
            check($sformatf("rnd%0d_post%0d", g, j));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
